// File: rtl/wait_ram_if.sv
// rv32i memory bus bundle between the CPU (master) and a memory responder (slave).
interface wait_ram_if;
  logic [31:0] addr;
  logic [3:0]  wmask;
  logic        rstrb;
  logic        wstrb;
  logic [31:0] rdata;
  logic [31:0] wdata;
  logic        rbusy;
  logic        wbusy;

  modport master (output addr, wmask, rstrb, wstrb, wdata,
                  input  rdata, rbusy, wbusy);
  modport slave  (input  addr, wmask, rstrb, wstrb, wdata,
                  output rdata, rbusy, wbusy);
endinterface

// File: rtl/wait_ram.sv
// Word-organised RAM on the rv32i bus with programmable read/write wait states.
// Optional WAIT_RAM_PROTCHK_EN adds a sticky err output for protocol violations.
module wait_ram #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned WR_LAT     = 1
) (
  input  logic       clk,
  input  logic       rst,
`ifdef WAIT_RAM_PROTCHK_EN
  output logic       err,
`endif
  wait_ram_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [31:0]           mem [DEPTH];
  logic [1:0]            state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] word_q;
  logic [3:0]            mask_q;
  logic [31:0]           data_q;
  logic [ADDR_WIDTH-1:0] word_in;

  logic                  we;
  logic [ADDR_WIDTH-1:0] we_word;
  logic [3:0]            we_mask;
  logic [31:0]           we_data;

  logic                  unused_addr_bits;

  assign word_in          = bus.addr[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^{bus.addr[31:ADDR_WIDTH+2], bus.addr[1:0]};

  // Zero-latency writes commit straight from the bus; delayed ones from the latches.
  always_comb begin
    we      = 1'b0;
    we_word = word_q;
    we_mask = mask_q;
    we_data = data_q;
    if (state == IDLE && bus.wstrb && WR_LAT == 0) begin
      we      = 1'b1;
      we_word = word_in;
      we_mask = bus.wmask;
      we_data = bus.wdata;
    end else if (state == WR && cnt == 4'd0) begin
      we = 1'b1;
    end
  end

  // Gated by rst so a write due at an edge during reset is dropped.
  always_ff @(posedge clk) begin
    if (we && rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (we_mask[i]) mem[we_word][8*i +: 8] <= we_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      word_q    <= '0;
      mask_q    <= '0;
      data_q    <= '0;
      bus.rdata <= '0;
      bus.rbusy <= 1'b0;
      bus.wbusy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.wstrb) begin
            word_q <= word_in;
            mask_q <= bus.wmask;
            data_q <= bus.wdata;
            if (WR_LAT != 0) begin
              cnt       <= 4'(WR_LAT - 1);
              state     <= WR;
              bus.wbusy <= 1'b1;
            end
          end else if (bus.rstrb) begin
            word_q <= word_in;
            if (RD_LAT == 0) begin
              bus.rdata <= mem[word_in];
            end else begin
              cnt       <= 4'(RD_LAT - 1);
              state     <= RD;
              bus.rbusy <= 1'b1;
            end
          end
        end
        RD: begin
          if (cnt == 4'd0) begin
            bus.rdata <= mem[word_q];
            bus.rbusy <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        WR: begin
          if (cnt == 4'd0) begin
            bus.wbusy <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WAIT_RAM_PROTCHK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if ((state != IDLE && (bus.rstrb || bus.wstrb)) ||
                 (state == IDLE && bus.rstrb && bus.wstrb)) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_wait_ram.sv
// Directed bench for wait_ram: a wait-state instance (2/1) and a zero-wait instance (0/0).
module tb_wait_ram;

  localparam int unsigned RD_A = 2;
  localparam int unsigned WR_A = 1;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [31:0] last_rd;
  logic        overlap;

  wait_ram_if bus_a ();
  wait_ram_if bus_b ();

`ifdef WAIT_RAM_PROTCHK_EN
  logic err_a;
  logic err_b;
`endif

  wait_ram #(.ADDR_WIDTH(10), .RD_LAT(RD_A), .WR_LAT(WR_A)) dut_a (
    .clk (clk),
    .rst (rst),
`ifdef WAIT_RAM_PROTCHK_EN
    .err (err_a),
`endif
    .bus (bus_a)
  );

  wait_ram #(.ADDR_WIDTH(10), .RD_LAT(0), .WR_LAT(0)) dut_b (
    .clk (clk),
    .rst (rst),
`ifdef WAIT_RAM_PROTCHK_EN
    .err (err_b),
`endif
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;   // write data, or expected read data
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d,
                          input string tag);
    int n;
    n = 0;
    bus_a.addr  = a;
    bus_a.wmask = m;
    bus_a.wdata = d;
    bus_a.wstrb = 1'b1;
    @(posedge clk); #1;
    bus_a.wstrb = 1'b0;
    while (bus_a.wbusy && n < 20) begin
      if (bus_a.rbusy) overlap = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " wr_lat"}, 32'(n), 32'(WR_A));
    chk({tag, " rdata_hold"}, bus_a.rdata, last_rd);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
    int n;
    n = 0;
    bus_a.addr  = a;
    bus_a.rstrb = 1'b1;
    @(posedge clk); #1;
    bus_a.rstrb = 1'b0;
    while (bus_a.rbusy && n < 20) begin
      if (bus_a.wbusy) overlap = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " rd_lat"}, 32'(n), 32'(RD_A));
    chk({tag, " rdata"}, bus_a.rdata, exp);
    last_rd = exp;
  endtask

  initial begin
    logic [31:0] pat;
    checks  = 0;
    errors  = 0;
    last_rd = '0;
    overlap = 1'b0;
    rst     = 1'b0;
    bus_a.addr = '0; bus_a.wmask = '0; bus_a.wdata = '0; bus_a.rstrb = 1'b0; bus_a.wstrb = 1'b0;
    bus_b.addr = '0; bus_b.wmask = '0; bus_b.wdata = '0; bus_b.rstrb = 1'b0; bus_b.wstrb = 1'b0;

    vecs[0]  = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF};
    vecs[1]  = '{1'b0, 32'h0000_0010, 4'h0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h0000_0020, 4'hF, 32'h1122_3344};
    vecs[3]  = '{1'b1, 32'h0000_0020, 4'h5, 32'hAABB_CCDD};
    vecs[4]  = '{1'b0, 32'h0000_0020, 4'h0, 32'h11BB_33DD};
    vecs[5]  = '{1'b1, 32'h0000_0024, 4'hF, 32'h1122_3344};
    vecs[6]  = '{1'b1, 32'h0000_0024, 4'h0, 32'hAABB_CCDD};
    vecs[7]  = '{1'b0, 32'h0000_0024, 4'h0, 32'h1122_3344};
    vecs[8]  = '{1'b1, 32'h0000_1000, 4'hF, 32'h5A5A_5A5A};
    vecs[9]  = '{1'b0, 32'h0000_0000, 4'h0, 32'h5A5A_5A5A};
    vecs[10] = '{1'b0, 32'hFFFF_F003, 4'h0, 32'h5A5A_5A5A};
    vecs[11] = '{1'b0, 32'h0000_0013, 4'h0, 32'hDEAD_BEEF};

    repeat (2) @(posedge clk);
    #1;
    chk("reset rdata", bus_a.rdata, 32'h0);
    chk("reset rbusy", 32'(bus_a.rbusy), 32'h0);
    chk("reset wbusy", 32'(bus_a.wbusy), 32'h0);
`ifdef WAIT_RAM_PROTCHK_EN
    chk("reset err", 32'(err_a), 32'h0);
`endif
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].mask, vecs[i].data, $sformatf("vec%0d", i));
      else               do_read(vecs[i].addr, vecs[i].data, $sformatf("vec%0d", i));
    end
`ifdef WAIT_RAM_PROTCHK_EN
    chk("err clean traffic", 32'(err_a), 32'h0);
`endif

    // Both strobes in IDLE: write wins, read dropped.
    bus_a.addr = 32'h40; bus_a.wmask = 4'hF; bus_a.wdata = 32'h1234_5678;
    bus_a.wstrb = 1'b1; bus_a.rstrb = 1'b1;
    @(posedge clk); #1;
    bus_a.wstrb = 1'b0; bus_a.rstrb = 1'b0;
    chk("both wbusy", 32'(bus_a.wbusy), 32'h1);
    chk("both rbusy", 32'(bus_a.rbusy), 32'h0);
    @(posedge clk); #1;
    chk("both wbusy fall", 32'(bus_a.wbusy), 32'h0);
    chk("both rdata hold", bus_a.rdata, last_rd);
    do_read(32'h40, 32'h1234_5678, "both readback");
`ifdef WAIT_RAM_PROTCHK_EN
    chk("err both strobes", 32'(err_a), 32'h1);
`endif

    // Reset during an in-flight write to a word holding zero.
    do_write(32'h30, 4'hF, 32'h0, "pre30");
    bus_a.addr = 32'h30; bus_a.wmask = 4'hF; bus_a.wdata = 32'hFFFF_FFFF; bus_a.wstrb = 1'b1;
    @(posedge clk); #1;
    bus_a.wstrb = 1'b0;
    chk("midwr wbusy", 32'(bus_a.wbusy), 32'h1);
    rst = 1'b0;
    #1;
    chk("midrst wbusy", 32'(bus_a.wbusy), 32'h0);
    chk("midrst rbusy", 32'(bus_a.rbusy), 32'h0);
    chk("midrst rdata", bus_a.rdata, 32'h0);
`ifdef WAIT_RAM_PROTCHK_EN
    chk("midrst err", 32'(err_a), 32'h0);
`endif
    last_rd = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    do_read(32'h30, 32'h0, "aborted30");

    // Write strobe during rbusy is ignored.
    bus_a.addr = 32'h10; bus_a.rstrb = 1'b1;
    @(posedge clk); #1;
    bus_a.rstrb = 1'b0;
    bus_a.wmask = 4'hF; bus_a.wdata = 32'h0; bus_a.wstrb = 1'b1;
    @(posedge clk); #1;
    bus_a.wstrb = 1'b0;
    chk("ign wbusy", 32'(bus_a.wbusy), 32'h0);
    chk("ign rbusy", 32'(bus_a.rbusy), 32'h1);
    @(posedge clk); #1;
    chk("ign rbusy fall", 32'(bus_a.rbusy), 32'h0);
    chk("ign rdata", bus_a.rdata, 32'hDEAD_BEEF);
    last_rd = 32'hDEAD_BEEF;
    do_read(32'h10, 32'hDEAD_BEEF, "ign readback");
`ifdef WAIT_RAM_PROTCHK_EN
    chk("err busy strobe", 32'(err_a), 32'h1);
`endif

    // Held rstrb: the strobe at the falling edge is dropped, next edge re-accepts.
    bus_a.addr = 32'h20; bus_a.rstrb = 1'b1;
    @(posedge clk); #1; chk("hold k rbusy",   32'(bus_a.rbusy), 32'h1);
    @(posedge clk); #1; chk("hold k1 rbusy",  32'(bus_a.rbusy), 32'h1);
    @(posedge clk); #1; chk("hold k2 rbusy",  32'(bus_a.rbusy), 32'h0);
    chk("hold k2 rdata", bus_a.rdata, 32'h11BB_33DD);
    @(posedge clk); #1; chk("hold k3 rbusy",  32'(bus_a.rbusy), 32'h1);
    bus_a.rstrb = 1'b0;
    @(posedge clk); #1; chk("hold k4 rbusy",  32'(bus_a.rbusy), 32'h1);
    @(posedge clk); #1; chk("hold k5 rbusy",  32'(bus_a.rbusy), 32'h0);
    last_rd = 32'h11BB_33DD;

    // Zero-wait instance: alternate write and read every cycle.
    for (int i = 0; i < 6; i++) begin
      pat = 32'h9E37_79B9 * 32'(i + 1);
      bus_b.addr = 32'(4 * i); bus_b.wmask = 4'hF; bus_b.wdata = pat;
      bus_b.wstrb = 1'b1; bus_b.rstrb = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("zw%0d wbusy", i), 32'(bus_b.wbusy), 32'h0);
      bus_b.wstrb = 1'b0; bus_b.rstrb = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("zw%0d rdata", i), bus_b.rdata, pat);
      chk($sformatf("zw%0d rbusy", i), 32'(bus_b.rbusy), 32'h0);
    end
    bus_b.rstrb = 1'b0;

    chk("busy overlap", 32'(overlap), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
